// File: rtl/conv_out_streamer.sv
// conv_out_streamer: buffers convolution results in a small FIFO and emits them as an AXI4-Stream master.
// Latency: a result written into an empty FIFO in cycle N is presented (tvalid) in cycle N+1.
// Backpressure: absorbed by the FIFO; when it is full and not popping, the incoming result is dropped and o_overflow is set.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid, i_data     one result per cycle from the window controller (cannot be stalled)
//   i_clear             synchronous frame abort: empties the FIFO and clears the counters and flags
//   m_axis_*            AXI4-Stream master (tdata/tvalid/tready/tlast, plus tuser = start of frame when enabled)
//   o_fill              registered FIFO occupancy
//   o_overflow          sticky "a result was dropped" flag
//   o_frame_done        one-cycle pulse in the cycle after the tlast handshake
//
// Optional feature macro: CONV_OUT_SOF_EN adds m_axis_tuser (first beat of each frame)
// and widens each FIFO entry by one bit.

module conv_out_streamer #(
  parameter int DATA_SIZE   = 32,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int DW          = 32,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  input  logic [DW-1:0]                 i_data,
  input  logic                          i_clear,
  output logic [DW-1:0]                 m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
`ifdef CONV_OUT_SOF_EN
  output logic                          m_axis_tuser,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   o_fill,
  output logic                          o_overflow,
  output logic                          o_frame_done
);

  localparam int OUT_DIM   = (DATA_SIZE - KERNEL_SIZE) / STRIDE + 1;
  localparam int FRAME_LEN = OUT_DIM * OUT_DIM;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int PW        = AW + 1;
  localparam int CW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  // Entry layout: [DW-1:0] data, [DW] last flag, [DW+1] first flag (SOF builds only).
`ifdef CONV_OUT_SOF_EN
  localparam int EW = DW + 2;
`else
  localparam int EW = DW + 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Storage and state
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_fill;
  logic [CW-1:0] r_in_cnt;
  logic          r_overflow;
  state_t        r_state;
  state_t        w_next_state;

  // Combinational helpers
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_pop_last;
  logic          w_last_flag;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;
  logic [PW-1:0] w_fill_next;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Registered head: the entry at the read pointer is presented directly, so
  // the outputs only move when the read pointer advances on a handshake.
  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  // i_clear overrides every other event in its cycle.
  assign w_pop      = !w_empty && m_axis_tready && !i_clear;
  assign w_push     = i_valid && !i_clear && (!w_full || w_pop);
  assign w_drop     = i_valid && !i_clear && w_full && !w_pop;
  assign w_pop_last = w_pop && w_head[DW];

  assign w_last_flag = (r_in_cnt == CW'(FRAME_LEN - 1));

`ifdef CONV_OUT_SOF_EN
  assign w_entry = {(r_in_cnt == '0), w_last_flag, i_data};
`else
  assign w_entry = {w_last_flag, i_data};
`endif

  always_comb begin
    w_fill_next = r_fill;
    case ({w_push, w_pop})
      2'b10:   w_fill_next = r_fill + PW'(1);
      2'b01:   w_fill_next = r_fill - PW'(1);
      default: w_fill_next = r_fill;
    endcase
  end

  // FIFO storage. Cleared on reset so tdata reads 0 straight out of reset.
  // On a full FIFO with a simultaneous pop the write lands in the slot being
  // popped, which is safe because the read pointer moves off it at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_fill <= w_fill_next;
    end
  end

  // Input beat counter advances on every valid beat, dropped or not, so the
  // tlast position stays locked to the frame even after an overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_cnt <= '0;
    end else if (i_clear) begin
      r_in_cnt <= '0;
    end else if (i_valid) begin
      r_in_cnt <= w_last_flag ? '0 : r_in_cnt + CW'(1);
    end
  end

  // Sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Output FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Output FSM: next state. Emptiness is judged on the post-edge occupancy so
  // IDLE always coincides with an empty FIFO and SEND with a non-empty one.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_push) w_next_state = S_SEND;
      end
      S_SEND: begin
        if (w_pop_last)              w_next_state = S_DONE;
        else if (w_fill_next == '0)  w_next_state = S_IDLE;
      end
      S_DONE: begin
        // A tlast pop here is only possible with one-beat frames.
        if (w_pop_last)              w_next_state = S_DONE;
        else if (w_fill_next != '0)  w_next_state = S_SEND;
        else                         w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (i_clear) w_next_state = S_IDLE;
  end

  // Outputs
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_head[DW-1:0];
  assign m_axis_tlast  = w_head[DW];
`ifdef CONV_OUT_SOF_EN
  assign m_axis_tuser  = w_head[DW+1];
`endif
  assign o_fill        = r_fill;
  assign o_overflow    = r_overflow;
  assign o_frame_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_conv_out_streamer.sv
module tb_conv_out_streamer;

  localparam int DS    = 8;
  localparam int KS    = 3;
  localparam int ST    = 1;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int FLEN  = 36;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_clear = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
`ifdef CONV_OUT_SOF_EN
  logic          tuser;
`endif
  logic [2:0]    fill;
  logic          ovf;
  logic          done;

  always #5 clk = ~clk;

  conv_out_streamer #(
    .DATA_SIZE(DS), .KERNEL_SIZE(KS), .STRIDE(ST), .DW(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_valid(i_valid),
    .i_data(i_data),
    .i_clear(i_clear),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast(tlast),
`ifdef CONV_OUT_SOF_EN
    .m_axis_tuser(tuser),
`endif
    .o_fill(fill),
    .o_overflow(ovf),
    .o_frame_done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered results plus the frame-position count.
  typedef struct {
    logic [DW-1:0] d;
    bit            last;
    bit            first;
  } ent_t;

  ent_t          q[$];
  int            m_cnt  = 0;
  bit            m_ovf  = 0;
  bit            m_done = 0;
  logic [DW-1:0] dcnt   = '0;
  int            done_seen;

  task automatic model_reset();
    q.delete();
    m_cnt  = 0;
    m_ovf  = 0;
    m_done = 0;
  endtask

  task automatic model_step(input bit v, input bit r, input bit c, input logic [DW-1:0] d);
    bit   pop;
    bit   full;
    ent_t e;
    if (c) begin
      model_reset();
      return;
    end
    pop    = (q.size() != 0) && r;
    full   = (q.size() == DEPTH);
    m_done = pop && q[0].last;
    if (pop) void'(q.pop_front());
    if (v) begin
      if (full && !pop) begin
        m_ovf = 1;
      end else begin
        e.d     = d;
        e.last  = (m_cnt == FLEN - 1);
        e.first = (m_cnt == 0);
        q.push_back(e);
      end
      m_cnt = (m_cnt + 1) % FLEN;
    end
  endtask

  task automatic check_model();
    chk("model tvalid", tvalid, q.size() != 0);
    chk("model fill", fill, q.size());
    chk("model overflow", ovf, m_ovf);
    chk("model frame_done", done, m_done);
    if (q.size() != 0) begin
      chk("model tdata", tdata, q[0].d);
      chk("model tlast", tlast, q[0].last);
`ifdef CONV_OUT_SOF_EN
      chk("model tuser", tuser, q[0].first);
`endif
    end
  endtask

  // One clock cycle: check current outputs, drive inputs at the negedge,
  // advance the model, then wait for the next negedge.
  task automatic cycle(input bit v, input bit r, input bit c);
    check_model();
    i_valid = v;
    tready  = r;
    i_clear = c;
    i_data  = dcnt;
    model_step(v, r, c, dcnt);
    if (v) dcnt++;
    @(negedge clk);
    if (done) done_seen++;
  endtask

  typedef struct {
    int n;
    bit v;
    bit r;
    bit c;
    bit e_tv;
    int e_fill;
    int e_data;
    bit e_last;
    bit e_ovf;
    int e_done;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Phases applied back to back; expected values are the visible state at the end of each phase.
    tbl[0]  = '{1,  0, 1, 0, 0, 0, 0,   0, 0, 0};  // idle after reset
    tbl[1]  = '{36, 1, 1, 0, 1, 1, 35,  1, 0, 0};  // full frame streaming, data 0..35
    tbl[2]  = '{1,  0, 1, 0, 0, 0, 0,   0, 0, 1};  // tlast popped, frame_done pulse
    tbl[3]  = '{4,  1, 0, 0, 1, 4, 36,  0, 0, 0};  // fill under backpressure
    tbl[4]  = '{3,  1, 1, 0, 1, 4, 39,  0, 0, 0};  // full with simultaneous pop
    tbl[5]  = '{1,  1, 0, 0, 1, 4, 39,  0, 1, 0};  // 5th write dropped
    tbl[6]  = '{5,  0, 0, 0, 1, 4, 39,  0, 1, 0};  // held while stalled
    tbl[7]  = '{4,  0, 1, 0, 0, 0, 0,   0, 1, 0};  // drain in order
    tbl[8]  = '{28, 1, 1, 0, 1, 1, 71,  1, 1, 0};  // rest of frame, tlast on 36th input
    tbl[9]  = '{1,  0, 1, 0, 0, 0, 0,   0, 1, 1};
    tbl[10] = '{72, 1, 1, 0, 1, 1, 143, 1, 1, 1};  // two frames back to back
    tbl[11] = '{2,  0, 1, 0, 0, 0, 0,   0, 1, 1};
    tbl[12] = '{18, 1, 1, 0, 1, 1, 161, 0, 1, 0};
    tbl[13] = '{2,  1, 0, 0, 1, 3, 161, 0, 1, 0};  // 20 beats in, 3 buffered
    tbl[14] = '{1,  1, 0, 1, 0, 0, 0,   0, 0, 0};  // clear with a colliding valid
    tbl[15] = '{36, 1, 1, 0, 1, 1, 200, 1, 0, 0};  // fresh frame after clear
    tbl[16] = '{1,  0, 1, 0, 0, 0, 0,   0, 0, 1};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset tvalid", tvalid, 0);
    chk("reset tdata", tdata, 0);
    chk("reset tlast", tlast, 0);
`ifdef CONV_OUT_SOF_EN
    chk("reset tuser", tuser, 0);
`endif
    chk("reset fill", fill, 0);
    chk("reset overflow", ovf, 0);
    chk("reset frame_done", done, 0);

    for (int i = 0; i < 17; i++) begin
      done_seen = 0;
      repeat (tbl[i].n) cycle(tbl[i].v, tbl[i].r, tbl[i].c);
      chk($sformatf("phase%0d tvalid", i), tvalid, tbl[i].e_tv);
      chk($sformatf("phase%0d fill", i), fill, tbl[i].e_fill);
      chk($sformatf("phase%0d overflow", i), ovf, tbl[i].e_ovf);
      chk($sformatf("phase%0d done_pulses", i), done_seen, tbl[i].e_done);
      if (tbl[i].e_tv) begin
        chk($sformatf("phase%0d tdata", i), tdata, tbl[i].e_data);
        chk($sformatf("phase%0d tlast", i), tlast, tbl[i].e_last);
      end
    end

    // Randomized traffic with occasional clears.
    for (int k = 0; k < 1500; k++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
    end

    // Asynchronous reset in the middle of a frame with data buffered.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check_model();
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("async reset tvalid", tvalid, 0);
    chk("async reset fill", fill, 0);
    chk("async reset tdata", tdata, 0);
    chk("async reset tlast", tlast, 0);
    chk("async reset overflow", ovf, 0);
    chk("async reset frame_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) cycle(0, 1, 0);
    repeat (40) cycle(1, 1, 0);
    repeat (3) cycle(0, 1, 0);
    check_model();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
